path_split: RTL and testbench

- Receive-side counterpart of the two-input merge path: takes one granted stream (req/gnt handshake, data one cycle after grant) and distributes it over two stop-controlled output channels.
- Words are steered in bursts of BURST to channel 1, then BURST to channel 2, alternating.
- Internal FIFO absorbs output stalls. Sits downstream of the merge path's req_o/gnt_i/data_o/valid_o.

---
 rtl/path_split.sv | 145 ++++++++++++++
 tb/tb_path_split.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/path_split.sv
// path_split: distributes a granted req/gnt stream over two stop-controlled channels in BURST-word runs.
// Optional per-channel accepted-word counters (cnt1_o/cnt2_o) are enabled by defining PATH_SPLIT_CNT_EN.
`default_nettype none

module path_split #(
   parameter int DWIDTH = 8,
   parameter int FDEPTH = 5,
   parameter int BURST  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   output logic              gnt_o,
   input  logic [DWIDTH-1:0] data_i,
   input  logic              valid_i,
   output logic [DWIDTH-1:0] data1_o,
   output logic              valid1_o,
   input  logic              stop1_i,
   output logic [DWIDTH-1:0] data2_o,
   output logic              valid2_o,
   input  logic              stop2_i,
`ifdef PATH_SPLIT_CNT_EN
   output logic [15:0]       cnt1_o,
   output logic [15:0]       cnt2_o,
`endif
   output logic              err_o
);

   localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
   localparam int CW = $clog2(FDEPTH + 1);
   localparam int OW = CW + 1;
   localparam int BW = $clog2(BURST + 1);

   typedef enum logic {CH1 = 1'b0, CH2 = 1'b1} sel_t;

   logic [DWIDTH-1:0] mem_q [FDEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              inflight_q, inflight_d;
   logic              out_valid_q, out_valid_d;
   logic [DWIDTH-1:0] out_data_q, out_data_d;
   logic [BW-1:0]     burst_q, burst_d;
   sel_t              sel_q, sel_d;
   logic              err_q, err_d;
   logic              full, accept, load, wr_en;
   logic [OW-1:0]     held;

   always_comb begin
      full   = (count_q == CW'(FDEPTH));
      accept = out_valid_q && !((sel_q == CH2) ? stop2_i : stop1_i);
      load   = (!out_valid_q || accept) && (count_q != '0);
      wr_en  = valid_i && inflight_q && !full;

      // Words owned by the block: FIFO, output stage, word in flight; an accept frees its slot now.
      held  = OW'(count_q) + OW'(out_valid_q) + OW'(inflight_q) - OW'(accept);
      gnt_o = req_i && (held < OW'(FDEPTH));

      inflight_d = gnt_o ? 1'b1 : (valid_i ? 1'b0 : inflight_q);
      err_d      = err_q || (valid_i && (!inflight_q || full));

      wr_ptr_d = wr_ptr_q;
      if (wr_en)
         wr_ptr_d = (wr_ptr_q == PW'(FDEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      rd_ptr_d = rd_ptr_q;
      if (load)
         rd_ptr_d = (rd_ptr_q == PW'(FDEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q + CW'(wr_en) - CW'(load);

      out_valid_d = load || (out_valid_q && !accept);
      out_data_d  = load ? mem_q[rd_ptr_q] : out_data_q;

      burst_d = burst_q;
      sel_d   = sel_q;
      if (accept) begin
         if (burst_q == BW'(BURST - 1)) begin
            burst_d = '0;
            sel_d   = (sel_q == CH1) ? CH2 : CH1;
         end else begin
            burst_d = burst_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         inflight_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         burst_q     <= '0;
         sel_q       <= CH1;
         err_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         inflight_q  <= inflight_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         burst_q     <= burst_d;
         sel_q       <= sel_d;
         err_q       <= err_d;
      end
   end

   assign valid1_o = out_valid_q && (sel_q == CH1);
   assign valid2_o = out_valid_q && (sel_q == CH2);
   assign data1_o  = out_data_q;
   assign data2_o  = out_data_q;
   assign err_o    = err_q;

`ifdef PATH_SPLIT_CNT_EN
   logic [15:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;

   always_comb begin
      cnt1_d = cnt1_q;
      cnt2_d = cnt2_q;
      if (accept && sel_q == CH1) cnt1_d = cnt1_q + 16'd1;
      if (accept && sel_q == CH2) cnt2_d = cnt2_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt1_q <= '0;
         cnt2_q <= '0;
      end else begin
         cnt1_q <= cnt1_d;
         cnt2_q <= cnt2_d;
      end
   end

   assign cnt1_o = cnt1_q;
   assign cnt2_o = cnt2_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_path_split.sv
// tb_path_split: directed and randomized stimulus for path_split, checked against a queue-based model.
`default_nettype none

module tb_path_split;
   localparam int DWIDTH = 8;
   localparam int FDEPTH = 5;
   localparam int BURST  = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_i, valid_i, stop1_i, stop2_i;
   logic [DWIDTH-1:0] data_i;
   logic              gnt_o, valid1_o, valid2_o, err_o;
   logic [DWIDTH-1:0] data1_o, data2_o;
`ifdef PATH_SPLIT_CNT_EN
   logic [15:0]       cnt1_o, cnt2_o;
`endif

   path_split #(.DWIDTH(DWIDTH), .FDEPTH(FDEPTH), .BURST(BURST)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o), .data_i(data_i), .valid_i(valid_i),
      .data1_o(data1_o), .valid1_o(valid1_o), .stop1_i(stop1_i),
      .data2_o(data2_o), .valid2_o(valid2_o), .stop2_i(stop2_i),
`ifdef PATH_SPLIT_CNT_EN
      .cnt1_o(cnt1_o), .cnt2_o(cnt2_o),
`endif
      .err_o(err_o)
   );

   always #5 clk = ~clk;

   int total = 0, fails = 0;
   int granted, accepted, limit, cyc, first_acc, last_acc;
   logic              pend, exp_err, seq_data, prev_hold;
   logic [1:0]        prev_v;
   logic [DWIDTH-1:0] pend_data, word_ctr, prev_d;
   logic [DWIDTH-1:0] q[$];

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      granted = 0; accepted = 0; pend = 1'b0; exp_err = 1'b0;
      prev_hold = 1'b0; first_acc = -1; last_acc = -1; word_ctr = '0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; req_i = 1'b0; valid_i = 1'b0; stop1_i = 1'b0; stop2_i = 1'b0;
      #1;
      chk(valid1_o, 0, "rst_valid1");
      chk(valid2_o, 0, "rst_valid2");
      chk(data1_o, 0, "rst_data1");
      chk(data2_o, 0, "rst_data2");
      chk(err_o, 0, "rst_err");
      chk(gnt_o, 0, "rst_gnt");
      model_clear();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // One clock: upstream answers last cycle's grant, then outputs are checked on the falling edge.
   task automatic step(input logic r, input logic s1, input logic s2, input logic force_v);
      logic a1, a2, eg;
      @(posedge clk); #1;
      valid_i = pend | force_v;
      data_i  = pend ? pend_data : DWIDTH'($urandom);
      req_i   = r && (limit > 0);
      stop1_i = s1;
      stop2_i = s2;
      @(negedge clk);
      cyc++;
      a1 = valid1_o && !stop1_i;
      a2 = valid2_o && !stop2_i;
      eg = req_i && ((granted - accepted - int'(a1 || a2)) < FDEPTH);
      chk(gnt_o, eg, "gnt");
      chk(valid1_o && valid2_o, 0, "one_valid");
      if (prev_hold) begin
         chk({valid1_o, valid2_o}, prev_v, "hold_valid");
         chk(data1_o, prev_d, "hold_data");
      end
      if (a1 || a2) begin
         chk(q.size() != 0, 1, "unexpected_word");
         if (q.size() != 0) begin
            chk(data1_o, q[0], "data");
            chk(a2, (accepted / BURST) % 2, "channel");
            void'(q.pop_front());
         end
         accepted++;
         if (first_acc < 0) first_acc = cyc;
         last_acc = cyc;
      end
      chk(err_o, exp_err, "err");
      if (force_v && !pend) exp_err = 1'b1;
      else if (valid_i) q.push_back(data_i);
      if (gnt_o) begin
         granted++;
         limit--;
         pend = 1'b1;
         pend_data = seq_data ? word_ctr : DWIDTH'($urandom);
         word_ctr++;
      end else begin
         pend = 1'b0;
      end
      prev_hold = (valid1_o && stop1_i) || (valid2_o && stop2_i);
      prev_v    = {valid1_o, valid2_o};
      prev_d    = data1_o;
   endtask

   task automatic drain(input int bound);
      int n = 0;
      while (n < bound && !(limit == 0 && !pend && q.size() == 0 && accepted == granted)) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         n++;
      end
      chk(limit == 0 && !pend && q.size() == 0 && accepted == granted, 1, "drain_done");
   endtask

   initial begin
      rst = 1'b1; req_i = 1'b0; valid_i = 1'b0; stop1_i = 1'b0; stop2_i = 1'b0; data_i = '0;
      cyc = 0; limit = 0; seq_data = 1'b1;
      model_clear();
      repeat (2) @(posedge clk);
      do_reset();

      // 25 sequential words, no backpressure
      limit = 25;
      drain(100);
      chk(accepted, 25, "run25_count");
      chk(last_acc - first_acc, 24, "run25_throughput");
`ifdef PATH_SPLIT_CNT_EN
      chk(cnt1_o, 15, "cnt1");
      chk(cnt2_o, 10, "cnt2");
`endif

      // channel 1 stalled with 8 words offered
      do_reset();
      limit = 8;
      repeat (12) step(1'b1, 1'b1, 1'($urandom), 1'b0);
      chk(granted, FDEPTH, "stall_grants");
      chk(q.size(), FDEPTH, "stall_held");
      chk(valid1_o, 1, "stall_valid1");
      drain(60);
      chk(accepted, 8, "stall_delivered");

      // stop2 toggling every cycle across a ch1 and ch2 burst
      do_reset();
      limit = 30;
      for (int i = 0; i < 80; i++) step(1'b1, 1'b0, 1'(i % 2), 1'b0);
      drain(60);
      chk(accepted, 30, "toggle_delivered");

      // reset after 7 words on ch1, then a fresh run starting on ch1
      do_reset();
      limit = 20;
      for (int i = 0; i < 50 && accepted < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      chk(accepted, 7, "mid_reached7");
      do_reset();
      limit = 12;
      drain(60);
      chk(accepted, 12, "after_reset_count");

      // randomized traffic and backpressure
      do_reset();
      seq_data = 1'b0;
      limit = 1000;
      repeat (500) step($urandom % 4 != 0, $urandom % 3 == 0, $urandom % 3 == 0, 1'b0);
      limit = 0;
      drain(100);

      // unsolicited valid_i
      do_reset();
      step(1'b0, 1'b0, 1'b0, 1'b1);
      limit = 3;
      repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
      drain(40);
      chk(err_o, 1, "err_sticky");
      chk(accepted, 3, "err_no_extra_word");

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule

`default_nettype wire
